// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module   : seg7_scan_ctrl
// Purpose  : Round-robin scan of N common-anode digits through one shared BCD
//            decoder, with per-digit register file and dwell/blank timing.
//            Optional leading-zero blanking enabled by defining SEG7_LZB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl #(
  parameter int N_DIG     = 4,
  parameter int DWELL     = 1000,
  parameter int BLANK_CYC = 16,
  localparam int IW       = $clog2(N_DIG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IW-1:0]    wr_idx,
  input  logic [3:0]       wr_data,
  output logic             b3,
  output logic             b2,
  output logic             b1,
  output logic             b0,
  output logic [N_DIG-1:0] dig_sel,
  output logic             blank,
  output logic             frame_tick
);

  localparam int TMAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      dreg [N_DIG];
  logic [IW-1:0]   cur_idx;
  logic [TW-1:0]   timer;
  logic [3:0]      nib;
  logic            ready_ok;
  logic            wr_fire;
  logic [3:0]      eff [N_DIG];
  logic [3:0]      cur_val;
  logic            lz_dark;

  assign {b3, b2, b1, b0} = nib;

  // Only the digit currently lit is protected from writes.
  always_comb begin
    wr_ready = ready_ok && !((state == ST_SHOW) && (wr_idx == cur_idx));
    wr_fire  = wr_valid && wr_ready;
  end

  // Effective register contents including a write landing on this edge, so a
  // write during the last BLANK cycle is the value that gets displayed.
  always_comb begin
    for (int i = 0; i < N_DIG; i++) begin
      eff[i] = (wr_fire && (wr_idx == IW'(i))) ? wr_data : dreg[i];
    end
    cur_val = eff[cur_idx];
  end

`ifdef SEG7_LZB_EN
  logic upper_nz;
  always_comb begin
    upper_nz = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if ((IW'(i) >= cur_idx) && (eff[i] != 4'd0)) upper_nz = 1'b1;
    end
    lz_dark = (cur_idx != '0) && !upper_nz;
  end
`else
  always_comb lz_dark = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      for (int i = 0; i < N_DIG; i++) dreg[i] <= 4'd0;
      cur_idx    <= '0;
      timer      <= '0;
      nib        <= 4'd0;
      dig_sel    <= '0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
      ready_ok   <= 1'b0;
    end else begin
      ready_ok   <= 1'b1;
      frame_tick <= 1'b0;
      for (int i = 0; i < N_DIG; i++) begin
        if (wr_fire && (wr_idx == IW'(i))) dreg[i] <= wr_data;
      end

      if (!en) begin
        state   <= ST_IDLE;
        cur_idx <= '0;
        timer   <= '0;
        dig_sel <= '0;
        blank   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_BLANK;
            cur_idx <= '0;
            timer   <= '0;
            dig_sel <= '0;
            blank   <= 1'b1;
          end
          ST_BLANK: begin
            if (timer == TW'(BLANK_CYC - 1)) begin
              state <= ST_SHOW;
              timer <= '0;
              nib   <= cur_val;
              if (lz_dark) begin
                dig_sel <= '0;
                blank   <= 1'b1;
              end else begin
                dig_sel <= N_DIG'(1) << cur_idx;
                blank   <= 1'b0;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_SHOW: begin
            if (timer == TW'(DWELL - 1)) begin
              state      <= ST_BLANK;
              timer      <= '0;
              dig_sel    <= '0;
              blank      <= 1'b1;
              frame_tick <= (cur_idx == IW'(N_DIG - 1));
              cur_idx    <= (cur_idx == IW'(N_DIG - 1)) ? '0 : cur_idx + 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            dig_sel <= '0;
            blank   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
